// File: rtl/alu24_op_sequencer_if.sv
// Bus between the CPU control path, the 24-bit ALU and the op sequencer.
//   Cmd*  : command valid/ready channel (CPU -> sequencer)
//   Alu*  : operands to / result and flags from the combinational ALU
//   Rsp*  : response valid/ready channel (sequencer -> CPU)
//   Busy  : sequencer not idle
// Modports: slave = sequencer view, master = surrounding environment view.
interface alu24_op_sequencer_if #(
  parameter int DATA_W  = 24,
  parameter int SHAMT_W = 4
);
  logic               CmdValid;
  logic               CmdReady;
  logic [DATA_W-1:0]  CmdA;
  logic [DATA_W-1:0]  CmdB;
  logic [SHAMT_W-1:0] CmdShamt;
  logic               CmdBNegate;
  logic [2:0]         CmdOp;
  logic               CmdMul;

  logic [DATA_W-1:0]  AluA;
  logic [DATA_W-1:0]  AluB;
  logic [SHAMT_W-1:0] AluShamt;
  logic               AluBNegate;
  logic [2:0]         AluOp;
  logic [DATA_W-1:0]  AluResult;
  logic               AluZero;
  logic               AluOverflow;
  logic               AluCarryOut;

  logic               RspValid;
  logic               RspReady;
  logic [DATA_W-1:0]  RspResult;
  logic               RspZero;
  logic               RspOverflow;
  logic               RspCarryOut;

  logic               Busy;

  modport slave (
    input  CmdValid, CmdA, CmdB, CmdShamt, CmdBNegate, CmdOp, CmdMul,
    output CmdReady,
    output AluA, AluB, AluShamt, AluBNegate, AluOp,
    input  AluResult, AluZero, AluOverflow, AluCarryOut,
    output RspValid, RspResult, RspZero, RspOverflow, RspCarryOut,
    input  RspReady,
    output Busy
  );

  modport master (
    output CmdValid, CmdA, CmdB, CmdShamt, CmdBNegate, CmdOp, CmdMul,
    input  CmdReady,
    input  AluA, AluB, AluShamt, AluBNegate, AluOp,
    output AluResult, AluZero, AluOverflow, AluCarryOut,
    input  RspValid, RspResult, RspZero, RspOverflow, RspCarryOut,
    output RspReady,
    input  Busy
  );
endinterface

// File: rtl/alu24_op_sequencer.sv
// Clocked issuing end of the 24-bit ALU. Accepts one command per valid/ready
// handshake, holds the ALU operands for a settle window, captures the ALU result
// and flags into a valid/ready response. Also performs an unsigned DATA_W x DATA_W
// multiply (low DATA_W bits) as DATA_W shift-and-add steps through the same ALU.
// Ports:
//   Clock  : rising-edge clock
//   ResetN : synchronous reset, active low
//   bus    : command, ALU and response channels (slave view)
//
// state | meaning
// IDLE  | CmdReady=1, waiting for a command
// ISSUE | plain op operands on Alu*, waiting out the settle window
// MUL   | multiply step in progress (acc + mcand on Alu*)
// RESP  | RspValid=1, holding response until RspReady
module alu24_op_sequencer #(
  parameter int         DATA_W        = 24,
  parameter int         SHAMT_W       = 4,
  parameter int         SETTLE_CYCLES = 1,
  parameter logic [2:0] ADD_OP        = 3'b010
) (
  input logic                  Clock,
  input logic                  ResetN,
  alu24_op_sequencer_if.slave  bus
);

  localparam int              CNT_W       = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
  localparam logic [CNT_W-1:0] SETTLE_INIT = CNT_W'(SETTLE_CYCLES - 1);
  localparam logic [4:0]      LAST_STEP   = 5'(DATA_W - 1);

  typedef enum logic [1:0] {IDLE, ISSUE, MUL, RESP} state_t;

  state_t             state;
  logic [CNT_W-1:0]   settle_cnt;
  logic [4:0]         step;
  logic [DATA_W-1:0]  acc;
  logic [DATA_W-1:0]  mcand;
  logic [DATA_W-1:0]  mplier;
  logic               mul_ovf;
  logic               shifted_nz;   // some 1 has been shifted out of mcand

  logic               settle_done;
  logic               take_add;
  logic [DATA_W-1:0]  acc_next;
  logic               ovf_next;

  assign settle_done = (settle_cnt == '0);
  assign take_add    = mplier[step];
  assign acc_next    = take_add ? bus.AluResult : acc;
  // Product reaches 2^DATA_W if a taken add carries, or a taken partial product
  // already lost high bits to the shift.
  assign ovf_next    = mul_ovf | (take_add & (bus.AluCarryOut | shifted_nz));

  always_ff @(posedge Clock) begin
    if (!ResetN) begin
      state          <= IDLE;
      settle_cnt     <= '0;
      step           <= '0;
      acc            <= '0;
      mcand          <= '0;
      mplier         <= '0;
      mul_ovf        <= 1'b0;
      shifted_nz     <= 1'b0;
      bus.CmdReady   <= 1'b1;
      bus.Busy       <= 1'b0;
      bus.AluA       <= '0;
      bus.AluB       <= '0;
      bus.AluShamt   <= '0;
      bus.AluBNegate <= 1'b0;
      bus.AluOp      <= '0;
      bus.RspValid   <= 1'b0;
      bus.RspResult  <= '0;
      bus.RspZero    <= 1'b0;
      bus.RspOverflow <= 1'b0;
      bus.RspCarryOut <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.CmdValid && bus.CmdReady) begin
            bus.CmdReady <= 1'b0;
            bus.Busy     <= 1'b1;
            settle_cnt   <= SETTLE_INIT;
            if (bus.CmdMul) begin
              state          <= MUL;
              step           <= '0;
              acc            <= '0;
              mcand          <= bus.CmdA;
              mplier         <= bus.CmdB;
              mul_ovf        <= 1'b0;
              shifted_nz     <= 1'b0;
              bus.AluA       <= '0;
              bus.AluB       <= bus.CmdA;
              bus.AluShamt   <= '0;
              bus.AluBNegate <= 1'b0;
              bus.AluOp      <= ADD_OP;
            end else begin
              state          <= ISSUE;
              bus.AluA       <= bus.CmdA;
              bus.AluB       <= bus.CmdB;
              bus.AluShamt   <= bus.CmdShamt;
              bus.AluBNegate <= bus.CmdBNegate;
              bus.AluOp      <= bus.CmdOp;
            end
          end
        end

        ISSUE: begin
          if (settle_done) begin
            state           <= RESP;
            bus.RspValid    <= 1'b1;
            bus.RspResult   <= bus.AluResult;
            bus.RspZero     <= bus.AluZero;
            bus.RspOverflow <= bus.AluOverflow;
            bus.RspCarryOut <= bus.AluCarryOut;
          end else begin
            settle_cnt <= settle_cnt - CNT_W'(1);
          end
        end

        MUL: begin
          if (settle_done) begin
            acc        <= acc_next;
            mul_ovf    <= ovf_next;
            mcand      <= mcand << 1;
            shifted_nz <= shifted_nz | mcand[DATA_W-1];
            if (step == LAST_STEP) begin
              // Alu* keep the final step's operands while the response is held.
              state           <= RESP;
              bus.RspValid    <= 1'b1;
              bus.RspResult   <= acc_next;
              bus.RspZero     <= (acc_next == '0);
              bus.RspOverflow <= ovf_next;
              bus.RspCarryOut <= 1'b0;
            end else begin
              step       <= step + 5'd1;
              settle_cnt <= SETTLE_INIT;
              bus.AluA   <= acc_next;
              bus.AluB   <= mcand << 1;
            end
          end else begin
            settle_cnt <= settle_cnt - CNT_W'(1);
          end
        end

        RESP: begin
          if (bus.RspReady) begin
            state        <= IDLE;
            bus.RspValid <= 1'b0;
            bus.CmdReady <= 1'b1;
            bus.Busy     <= 1'b0;
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu24_op_sequencer.sv
module tb_alu24_op_sequencer;

  localparam int         DATA_W = 24;
  localparam int         SHAMT_W = 4;
  localparam int         SETTLE = 1;
  localparam logic [2:0] ADD_OP = 3'b010;

  typedef struct packed {
    logic [23:0] res;
    logic        zero;
    logic        ovf;
    logic        carry;
  } rsp_t;

  logic Clock;
  logic ResetN;
  int   n_checks = 0;
  int   n_errors = 0;
  rsp_t sb[$];

  alu24_op_sequencer_if #(.DATA_W(DATA_W), .SHAMT_W(SHAMT_W)) bus ();

  alu24_op_sequencer #(
    .DATA_W(DATA_W), .SHAMT_W(SHAMT_W), .SETTLE_CYCLES(SETTLE), .ADD_OP(ADD_OP)
  ) dut (
    .Clock (Clock),
    .ResetN(ResetN),
    .bus   (bus)
  );

  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  // Reference behaviour of the combinational ALU sitting behind the sequencer.
  function automatic rsp_t alu_fn(input logic [23:0] a, input logic [23:0] b,
                                  input logic [3:0] sh, input logic bneg,
                                  input logic [2:0] op);
    rsp_t        r;
    logic [23:0] bb;
    logic [24:0] sum;
    bb  = bneg ? ~b : b;
    sum = {1'b0, a} + {1'b0, bb} + 25'(bneg);
    r   = '0;
    case (op)
      3'd0: r.res = a & bb;
      3'd1: r.res = a | bb;
      3'd2: begin
        r.res   = sum[23:0];
        r.carry = sum[24];
        r.ovf   = (a[23] == bb[23]) && (sum[23] != a[23]);
      end
      3'd3: r.res = a ^ bb;
      3'd4: r.res = a << sh;
      3'd5: r.res = a >> sh;
      3'd6: r.res = {23'd0, ($signed(a) < $signed(b))};
      default: r.res = bb;
    endcase
    r.zero = (r.res == 24'd0);
    return r;
  endfunction

  function automatic rsp_t mul_fn(input logic [23:0] a, input logic [23:0] b);
    rsp_t        r;
    logic [47:0] p;
    p       = {24'd0, a} * {24'd0, b};
    r.res   = p[23:0];
    r.zero  = (p[23:0] == 24'd0);
    r.ovf   = (p[47:24] != 24'd0);
    r.carry = 1'b0;
    return r;
  endfunction

  rsp_t alu_out;
  always_comb begin
    alu_out         = alu_fn(bus.AluA, bus.AluB, bus.AluShamt, bus.AluBNegate, bus.AluOp);
    bus.AluResult   = alu_out.res;
    bus.AluZero     = alu_out.zero;
    bus.AluOverflow = alu_out.ovf;
    bus.AluCarryOut = alu_out.carry;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Scoreboard: every drained response is compared against the oldest expectation.
  always @(negedge Clock) begin
    if (ResetN && bus.RspValid && bus.RspReady) begin
      check("sb_nonempty", 32'(sb.size() != 0), 32'd1);
      if (sb.size() != 0) begin
        rsp_t e;
        e = sb.pop_front();
        check("rsp_result", 32'(bus.RspResult), 32'(e.res));
        check("rsp_zero", 32'(bus.RspZero), 32'(e.zero));
        check("rsp_ovf", 32'(bus.RspOverflow), 32'(e.ovf));
        check("rsp_carry", 32'(bus.RspCarryOut), 32'(e.carry));
      end
    end
  end

  // Issue one command; optionally wait for RspValid, checking latency and that
  // the ALU operands stay put while the sequencer is busy.
  task automatic issue(input string tag, input logic [23:0] a, input logic [23:0] b,
                       input logic [3:0] sh, input logic bneg, input logic [2:0] op,
                       input logic mul, input bit wait_rsp);
    int k;
    int lat;
    k = 0;
    while (!bus.CmdReady && k < 100) begin
      @(posedge Clock); #1;
      k++;
    end
    check({tag, "_cmd_ready"}, 32'(bus.CmdReady), 32'd1);
    sb.push_back(mul ? mul_fn(a, b) : alu_fn(a, b, sh, bneg, op));
    bus.CmdValid   = 1'b1;
    bus.CmdA       = a;
    bus.CmdB       = b;
    bus.CmdShamt   = sh;
    bus.CmdBNegate = bneg;
    bus.CmdOp      = op;
    bus.CmdMul     = mul;
    @(posedge Clock); #1;
    bus.CmdValid   = 1'b0;
    bus.CmdA       = 24'($urandom);
    bus.CmdB       = 24'($urandom);
    bus.CmdShamt   = 4'($urandom);
    bus.CmdOp      = 3'($urandom);
    bus.CmdBNegate = 1'b0;
    bus.CmdMul     = 1'b0;
    if (wait_rsp) begin
      lat = 0;
      for (int i = 0; i < 200; i++) begin
        @(negedge Clock);
        if (bus.RspValid) break;
        if (lat == 0) begin
          check({tag, "_busy"}, 32'(bus.Busy), 32'd1);
          check({tag, "_alu_a"}, 32'(bus.AluA), mul ? 32'd0 : 32'(a));
          check({tag, "_alu_b"}, 32'(bus.AluB), 32'(a ^ (mul ? 24'd0 : (a ^ b))));
          check({tag, "_alu_op"}, 32'(bus.AluOp), mul ? 32'(ADD_OP) : 32'(op));
          check({tag, "_alu_bneg"}, 32'(bus.AluBNegate), mul ? 32'd0 : 32'(bneg));
        end else if (!mul) begin
          check({tag, "_alu_a_hold"}, 32'(bus.AluA), 32'(a));
          check({tag, "_alu_b_hold"}, 32'(bus.AluB), 32'(b));
        end
        if (!mul) check({tag, "_alu_shamt"}, 32'(bus.AluShamt), 32'(sh));
        check({tag, "_cmd_ready_busy"}, 32'(bus.CmdReady), 32'd0);
        lat++;
      end
      check({tag, "_latency"}, 32'(lat), mul ? 32'(24 * SETTLE) : 32'(SETTLE));
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, got no end expected finish");
    $fatal(1);
  end

  initial begin
    rsp_t bp_exp;
    ResetN         = 1'b0;
    bus.CmdValid   = 1'b0;
    bus.CmdA       = '0;
    bus.CmdB       = '0;
    bus.CmdShamt   = '0;
    bus.CmdBNegate = 1'b0;
    bus.CmdOp      = '0;
    bus.CmdMul     = 1'b0;
    bus.RspReady   = 1'b1;
    repeat (3) @(posedge Clock);
    @(negedge Clock);
    check("rst_cmd_ready", 32'(bus.CmdReady), 32'd1);
    check("rst_busy", 32'(bus.Busy), 32'd0);
    check("rst_rsp_valid", 32'(bus.RspValid), 32'd0);
    check("rst_alu_a", 32'(bus.AluA), 32'd0);
    check("rst_rsp_result", 32'(bus.RspResult), 32'd0);
    @(posedge Clock); #1;
    ResetN = 1'b1;

    issue("add", 24'd7, 24'd9, 4'd0, 1'b0, ADD_OP, 1'b0, 1'b1);
    issue("sub", 24'd9, 24'd9, 4'd0, 1'b1, ADD_OP, 1'b0, 1'b1);
    issue("sub_neg", 24'd3, 24'd5, 4'd0, 1'b1, ADD_OP, 1'b0, 1'b1);
    issue("add_ovf", 24'h7FFFFF, 24'd1, 4'd0, 1'b0, ADD_OP, 1'b0, 1'b1);
    issue("mul", 24'd1234, 24'd567, 4'd0, 1'b0, 3'd0, 1'b1, 1'b1);
    issue("mul_ovf", 24'h001000, 24'h001000, 4'd0, 1'b0, 3'd0, 1'b1, 1'b1);
    issue("mul_zero", 24'h123456, 24'd0, 4'd0, 1'b0, 3'd0, 1'b1, 1'b1);
    issue("mul_max1", 24'hFFFFFF, 24'd1, 4'd0, 1'b0, 3'd0, 1'b1, 1'b1);
    issue("mul_max2", 24'hFFFFFF, 24'd2, 4'd0, 1'b0, 3'd0, 1'b1, 1'b1);
    for (int i = 0; i < 6; i++)
      issue("rnd_op", 24'($urandom), 24'($urandom), 4'($urandom), 1'($urandom),
            3'($urandom_range(0, 7)), 1'b0, 1'b1);
    for (int i = 0; i < 2; i++)
      issue("rnd_mul_s", 24'($urandom_range(0, 4095)), 24'($urandom_range(0, 4095)),
            4'd0, 1'b0, 3'd0, 1'b1, 1'b1);
    issue("rnd_mul_l", 24'($urandom), 24'($urandom), 4'd0, 1'b0, 3'd0, 1'b1, 1'b1);

    // Backpressure: response must hold and new commands must be ignored.
    @(posedge Clock); #1;
    bus.RspReady = 1'b0;
    bp_exp = alu_fn(24'd100, 24'd23, 4'd0, 1'b0, ADD_OP);
    issue("bp", 24'd100, 24'd23, 4'd0, 1'b0, ADD_OP, 1'b0, 1'b1);
    for (int i = 0; i < 5; i++) begin
      @(posedge Clock); #1;
      bus.CmdValid = 1'b1;
      bus.CmdA     = 24'($urandom);
      bus.CmdMul   = 1'($urandom);
      @(negedge Clock);
      check("bp_rsp_valid", 32'(bus.RspValid), 32'd1);
      check("bp_rsp_result", 32'(bus.RspResult), 32'(bp_exp.res));
      check("bp_cmd_ready", 32'(bus.CmdReady), 32'd0);
    end
    @(posedge Clock); #1;
    bus.CmdValid = 1'b0;
    bus.RspReady = 1'b1;
    @(posedge Clock); #1;
    @(negedge Clock);
    check("drain_rsp_valid", 32'(bus.RspValid), 32'd0);
    check("drain_cmd_ready", 32'(bus.CmdReady), 32'd1);
    check("drain_rsp_keep", 32'(bus.RspResult), 32'(bp_exp.res));

    // Reset in the middle of a multiply: no response may appear.
    issue("mul_abort", 24'd1234, 24'd567, 4'd0, 1'b0, 3'd0, 1'b1, 1'b0);
    repeat (10) @(posedge Clock);
    #1;
    ResetN = 1'b0;
    @(posedge Clock); #1;
    ResetN = 1'b1;
    void'(sb.pop_back());
    @(negedge Clock);
    check("abort_busy", 32'(bus.Busy), 32'd0);
    check("abort_cmd_ready", 32'(bus.CmdReady), 32'd1);
    check("abort_rsp_valid", 32'(bus.RspValid), 32'd0);
    repeat (30) @(posedge Clock);
    #1;
    issue("post_rst_add", 24'd1, 24'd1, 4'd0, 1'b0, ADD_OP, 1'b0, 1'b1);

    @(posedge Clock); #1;
    @(negedge Clock);
    check("sb_drained", 32'(sb.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
